// File: rtl/seq_table_ctrl.sv
// seq_table_ctrl
//
// Owns the per-host sequence-number table and arbitrates single-port access
// between three requesters, with fixed priority update > alloc > lookup:
//   - session-manager counter updates (write only, no response)
//   - outgoing-message allocation (read-and-increment, feeds the converter)
//   - received-message expected-sequence lookups (read only)
// It also sequences the shared binary-to-BCD converter, so that only one
// allocation is being converted at any time.
//
// Build option:
//   SEQ_TABLE_SAT_EN - when defined, the increment saturates at all-ones
//                      instead of wrapping to INIT_SEQ. The alloc_ovf_o port
//                      then exists and pulses alongside alloc_rsp_valid_o.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   init_done_o          table initialised; every ready is 0 while low
//   upd_*                counter update (valid/ready, addr, seq)
//   alloc_*              allocation request (valid/ready, addr) and
//                        response (rsp_valid pulse, pre-increment rsp_seq)
//   alloc_ovf_o          saturation hit (only with SEQ_TABLE_SAT_EN)
//   lk_*                 lookup request (valid/ready, addr) and
//                        response (rsp_valid pulse, rsp_seq)
//   conv_start_o         one-cycle start pulse to the converter
//   conv_dat_o           value to convert, held until the next allocation
//   conv_done_i          converter finished
//   conv_busy_o          conversion outstanding
//   conv_err_o           one-cycle pulse when the converter times out

`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 4
`endif

module seq_table_ctrl #(
    parameter int          HOST_ADDR    = `HOST_ADDR_WIDTH,
    parameter int          SEQ_W        = 32,
    parameter int unsigned INIT_SEQ     = 1,
    parameter int          CONV_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 init_done_o,
    input  logic                 upd_valid_i,
    input  logic [HOST_ADDR-1:0] upd_addr_i,
    input  logic [SEQ_W-1:0]     upd_seq_i,
    output logic                 upd_ready_o,
    input  logic                 alloc_valid_i,
    input  logic [HOST_ADDR-1:0] alloc_addr_i,
    output logic                 alloc_ready_o,
    output logic                 alloc_rsp_valid_o,
    output logic [SEQ_W-1:0]     alloc_rsp_seq_o,
`ifdef SEQ_TABLE_SAT_EN
    output logic                 alloc_ovf_o,
`endif
    input  logic                 lk_valid_i,
    input  logic [HOST_ADDR-1:0] lk_addr_i,
    output logic                 lk_ready_o,
    output logic                 lk_rsp_valid_o,
    output logic [SEQ_W-1:0]     lk_rsp_seq_o,
    output logic                 conv_start_o,
    output logic [SEQ_W-1:0]     conv_dat_o,
    input  logic                 conv_done_i,
    output logic                 conv_busy_o,
    output logic                 conv_err_o
);

    localparam int               DEPTH    = 1 << HOST_ADDR;
    localparam int               TW       = $clog2(CONV_TIMEOUT + 1);
    localparam logic [SEQ_W-1:0] INIT_VAL = SEQ_W'(INIT_SEQ);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CONV} state_t;

    state_t               state;
    state_t               state_next;
    logic [HOST_ADDR-1:0] init_ptr;
    logic [TW-1:0]        tmo_cnt;
    logic [SEQ_W-1:0]     table_mem [DEPTH];

    logic                 accept_ok;
    logic                 alloc_allowed;
    logic [HOST_ADDR-1:0] rd_addr;
    logic [SEQ_W-1:0]     rd_data;
    logic [SEQ_W-1:0]     inc_seq;
    logic                 last_init;
    logic                 conv_timeout;
`ifdef SEQ_TABLE_SAT_EN
    logic                 sat_hit;
`endif

    // One grant per cycle. Readies are also held low while rst is asserted
    // so nothing is acknowledged in a cycle that is about to be discarded.
    assign accept_ok     = !rst && (state != ST_INIT);
    assign alloc_allowed = accept_ok && (state == ST_IDLE);
    assign upd_ready_o   = accept_ok && upd_valid_i;
    assign alloc_ready_o = alloc_allowed && alloc_valid_i && !upd_valid_i;
    assign lk_ready_o    = accept_ok && lk_valid_i && !upd_valid_i
                           && !(alloc_allowed && alloc_valid_i);
    assign init_done_o   = (state != ST_INIT);

    // Alloc and lookup share the single read port; the grant picks the address.
    assign rd_addr      = alloc_ready_o ? alloc_addr_i : lk_addr_i;
    assign rd_data      = table_mem[rd_addr];
    assign last_init    = (init_ptr == HOST_ADDR'(DEPTH - 1));
    assign conv_timeout = (tmo_cnt == TW'(CONV_TIMEOUT - 1));

    // An all-ones counter must never step to 0, since 0 is not a legal
    // sequence number: it either wraps to the start value or sticks.
    always_comb begin
        inc_seq = rd_data + SEQ_W'(1);
`ifdef SEQ_TABLE_SAT_EN
        sat_hit = 1'b0;
        if (rd_data == '1) begin
            inc_seq = rd_data;
            sat_hit = 1'b1;
        end
`else
        if (rd_data == '1) begin
            inc_seq = INIT_VAL;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // INIT sweeps the table once; IDLE waits for an allocation; CONV holds
    // off further allocations until the converter answers or times out.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (last_init) state_next = ST_IDLE;
            ST_IDLE: if (alloc_ready_o) state_next = ST_CONV;
            ST_CONV: if (conv_done_i || conv_timeout) state_next = ST_IDLE;
            default: state_next = ST_INIT;
        endcase
    end

    // Table storage needs no reset: INIT rewrites every entry after reset.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            table_mem[init_ptr] <= INIT_VAL;
        end else if (upd_ready_o) begin
            table_mem[upd_addr_i] <= upd_seq_i;
        end else if (alloc_ready_o) begin
            table_mem[alloc_addr_i] <= inc_seq;
        end
    end

    // Responses, converter handshake and timeout. The timeout counter is
    // cleared on the accepting edge, so it reads k in the k-th cycle after
    // conv_start_o, and the error fires CONV_TIMEOUT cycles after the start.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_ptr          <= '0;
            tmo_cnt           <= '0;
            alloc_rsp_valid_o <= 1'b0;
            alloc_rsp_seq_o   <= '0;
            lk_rsp_valid_o    <= 1'b0;
            lk_rsp_seq_o      <= '0;
            conv_start_o      <= 1'b0;
            conv_dat_o        <= '0;
            conv_busy_o       <= 1'b0;
            conv_err_o        <= 1'b0;
`ifdef SEQ_TABLE_SAT_EN
            alloc_ovf_o       <= 1'b0;
`endif
        end else begin
            alloc_rsp_valid_o <= alloc_ready_o;
            conv_start_o      <= alloc_ready_o;
            lk_rsp_valid_o    <= lk_ready_o;
            conv_err_o        <= 1'b0;
`ifdef SEQ_TABLE_SAT_EN
            alloc_ovf_o       <= alloc_ready_o && sat_hit;
`endif
            if (state == ST_INIT) begin
                init_ptr <= init_ptr + HOST_ADDR'(1);
            end
            if (alloc_ready_o) begin
                alloc_rsp_seq_o <= rd_data;
                conv_dat_o      <= rd_data;
                conv_busy_o     <= 1'b1;
                tmo_cnt         <= '0;
            end
            if (lk_ready_o) begin
                lk_rsp_seq_o <= rd_data;
            end
            if (state == ST_CONV) begin
                if (conv_done_i) begin
                    conv_busy_o <= 1'b0;
                end else if (conv_timeout) begin
                    conv_busy_o <= 1'b0;
                    conv_err_o  <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: doc/seq_table_ctrl.md
Name: seq_table_ctrl

Overview:
- Owns the per-host sequence-number table and arbitrates access to it between three requesters:
  - session-manager counter updates;
  - outgoing-message sequence allocation (read-and-increment);
  - received-message expected-sequence lookups.
- Sequences the shared binary-to-BCD converter so that only one allocation is in conversion at a time.
- Sits between the session manager / received message processor and the converter, replacing ad-hoc table access.

Parameters:
- HOST_ADDR, `HOST_ADDR_WIDTH, host index width; table depth DEPTH = 1<<HOST_ADDR.
- SEQ_W, 32, sequence counter width.
- INIT_SEQ, 1, value every entry holds after initialisation (FIX MsgSeqNum starts at 1).
- CONV_TIMEOUT, 64, cycles to wait for conv_done_i before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_done_o  out  1  table initialised; all readies are 0 while low
- upd_valid_i  in  1  counter update request
- upd_addr_i  in  HOST_ADDR  host to update
- upd_seq_i  in  SEQ_W  new counter value
- upd_ready_o  out  1  update accepted this cycle when valid&ready
- alloc_valid_i  in  1  outgoing allocation request
- alloc_addr_i  in  HOST_ADDR  destination host
- alloc_ready_o  out  1  allocation accepted
- alloc_rsp_valid_o  out  1  one-cycle pulse, allocated number valid
- alloc_rsp_seq_o  out  SEQ_W  allocated (pre-increment) number
- lk_valid_i  in  1  expected-sequence lookup
- lk_addr_i  in  HOST_ADDR  received-from host
- lk_ready_o  out  1  lookup accepted
- lk_rsp_valid_o  out  1  one-cycle pulse
- lk_rsp_seq_o  out  SEQ_W  current table value for host
- conv_start_o  out  1  one-cycle start to converter
- conv_dat_o  out  SEQ_W  binary value to convert, held stable until done
- conv_done_i  in  1  converter finished
- conv_busy_o  out  1  conversion outstanding
- conv_err_o  out  1  one-cycle pulse on conversion timeout

Behaviour:
- Reset (synchronous, active-high): FSM enters INIT, init pointer to 0. All outputs 0: readies, rsp valids, rsp data, conv_start_o, conv_dat_o, conv_busy_o, conv_err_o, init_done_o.
- INIT: writes INIT_SEQ to one entry per cycle, addresses 0..DEPTH-1. After entry DEPTH-1, init_done_o = 1 and FSM goes to IDLE. Initialisation takes DEPTH cycles.
- Arbitration: one table access per cycle, fixed priority update > alloc > lookup.
  - Exactly one ready is high, combinationally, for the highest-priority valid requester that is allowed.
  - Alloc is allowed only when the FSM is IDLE (not CONV).
  - Update and lookup are serviced in both IDLE and CONV.
- Update: entry[upd_addr_i] <= upd_seq_i at the accepting edge. No response.
- Alloc:
  - At the accepting edge: alloc_rsp_seq_o <= entry; entry <= entry+1; conv_dat_o <= entry.
  - Next cycle: alloc_rsp_valid_o = 1 and conv_start_o = 1, each for one cycle. conv_busy_o = 1 and FSM goes to CONV.
- Increment rule: entry = all-ones increments to INIT_SEQ, not 0.
- Lookup: lk_rsp_seq_o <= entry at accept; lk_rsp_valid_o = 1 the following cycle. Latency is 1.
- Ordering: an update accepted in cycle N is visible to any alloc or lookup accepted in cycle N+1 or later. Accesses to the same address in the same cycle cannot occur, because there is only one grant per cycle.
- CONV:
  - Timeout counter counts cycles from conv_start_o.
  - conv_done_i: conv_busy_o = 0 and FSM goes to IDLE on the next edge. A new alloc may be accepted in the cycle after done.
  - Counter reaches CONV_TIMEOUT without done: conv_err_o pulses, conv_busy_o = 0, FSM goes to IDLE. The table increment is not rolled back.
  - conv_done_i while in IDLE or INIT is ignored.
- Reset mid-operation: pending responses and the conversion are dropped, conv_busy_o = 0, and the table is re-initialised.
- Requesters must hold valid and addr/data stable until ready. The block does not latch unaccepted requests.

Optional Feature:
- Macro SEQ_TABLE_SAT_EN.
- Defined: increment saturates at all-ones. An alloc at all-ones returns all-ones, leaves the entry unchanged, and pulses extra output alloc_ovf_o alongside alloc_rsp_valid_o. alloc_ovf_o resets to 0.
- Undefined: wrap to INIT_SEQ as above; alloc_ovf_o port absent.

Test Plan:
- Reset, HOST_ADDR=4 → init_done_o rises after exactly 16 cycles. Lookups of hosts 0..15 all return 1.
- Alloc host 3 twice, driving conv_done_i 10 cycles after each conv_start_o → rsp 1 then 2; conv_dat_o = 1 then 2. Second alloc_ready_o stays 0 until the cycle after the first done. Lookup of host 3 then returns 3.
- upd, alloc and lk all valid on host 5 in the same cycle (upd_seq_i=100) → order update, alloc, lookup. Alloc rsp = 100, lookup rsp = 101.
- upd host 7 = 0xFFFFFFFF, then alloc host 7 → rsp 0xFFFFFFFF, next alloc returns 1. With SEQ_TABLE_SAT_EN instead: rsp 0xFFFFFFFF twice, alloc_ovf_o pulses twice.
- Alloc with conv_done_i never asserted → conv_err_o pulses exactly 64 cycles after conv_start_o. Lookups during the wait have latency 1. Alloc accepted afterward.
- Assert rst during CONV → all outputs 0 next cycle, INIT re-runs, and lookup returns 1 for the previously allocated host.
